// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that owns the select lines of a shared 4:1 mux.
//   A requester wins the mux and keeps it until it signals DONE, drops its
//   request, or uses up MAX_HOLD consecutive cycles. Every release is
//   followed by one guard cycle with no grant, and then the next requester
//   wins. Search order starts one past the previous owner.
//
// Ports
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   REQ    in   [3:0] request per requester
//   DONE   in   owner releases at the next edge (only meaningful while VALID)
//   S1     out  mux select MSB (owner index bit 1)
//   S2     out  mux select LSB (owner index bit 0)
//   GNT    out  [3:0] one-hot grant, zero when nobody owns the mux
//   VALID  out  high exactly when GNT is non-zero
//
// All outputs are registered.

module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic       S1,
    output logic       S2,
    output logic [3:0] GNT,
    output logic       VALID
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GUARD
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state, state_n;
    logic [1:0] last, last_n;
    logic [7:0] hcnt, hcnt_n;
    logic [3:0] gnt_n;
    logic       valid_n;
    logic       s1_n, s2_n;
    logic [1:0] winner;
    logic       release_now;

    // First index with REQ set, searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign winner      = rr_pick(REQ, last);
    // LAST always equals the current owner while in GRANT.
    assign release_now = DONE || !REQ[last] || (hcnt == HOLD_LIM);

    always_comb begin
        state_n = state;
        last_n  = last;
        hcnt_n  = hcnt;
        gnt_n   = GNT;
        valid_n = VALID;
        s1_n    = S1;
        s2_n    = S2;

        unique case (state)
            IDLE, GUARD: begin
                if (|REQ) begin
                    state_n = GRANT;
                    last_n  = winner;
                    hcnt_n  = 8'd1;
                    gnt_n   = 4'b0001 << winner;
                    valid_n = 1'b1;
                    s1_n    = winner[1];
                    s2_n    = winner[0];
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Select lines keep the old owner through the guard cycle.
                    state_n = GUARD;
                    hcnt_n  = '0;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                end else begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            last  <= 2'd3;
            hcnt  <= '0;
            GNT   <= '0;
            VALID <= 1'b0;
            S1    <= 1'b0;
            S2    <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            hcnt  <= hcnt_n;
            GNT   <= gnt_n;
            VALID <= valid_n;
            S1    <= s1_n;
            S2    <= s2_n;
        end
    end

endmodule
